// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink sequencer.
package led_blink_pkg;

    // Sequencer states: idle, LED lit, LED dark between blinks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

endpackage

// File: rtl/led_blink_phase_timer.sv
// Loadable down-counter that times one ON or OFF phase.
// Load with (phase length - 1); expired is high during the last cycle of the phase.
module phase_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expired
);

    logic [TW-1:0] count;

    // Count down to zero and hold there; a load restarts the phase.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/led_blink.sv
// LED blink sequencer: on an accepted start, blinks the LED blink_count times
// (ON_CYCLES lit, OFF_CYCLES dark between blinks), then pulses done.
// cancel aborts without done; every output comes straight from a flop.
module led_blink
    import led_blink_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] blink_count,
    input  logic             cancel,
    output logic             led,
    output logic             busy,
    output logic             done
);

    // Timer wide enough to hold the longer of the two phase lengths.
    localparam int MAX_PHASE = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW        = $clog2(MAX_PHASE + 1);

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             tmr_load;
    logic [TW-1:0]    tmr_load_val;
    logic             tmr_expired;
    logic             finish;

    phase_timer #(
        .TW (TW)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    // Next-state logic: acceptance, phase transitions, cancel and completion.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                // cancel wins over start here; a zero-length request is ignored
                if (!cancel && start && (blink_count != '0)) begin
                    state_nxt    = ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = ON_LOAD;
                end
            end
            ON: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (tmr_expired) begin
                    // last blink goes straight to IDLE with no trailing dark phase
                    if (remaining <= CNT_W'(1)) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt    = OFF;
                        tmr_load     = 1'b1;
                        tmr_load_val = OFF_LOAD;
                    end
                end
            end
            OFF: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (tmr_expired) begin
                    state_nxt    = ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = ON_LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            led   <= (state_nxt == ON);
            busy  <= (state_nxt != IDLE);
            done  <= finish;
        end
    end

    // Remaining-blink counter: loaded on acceptance, decremented as each
    // ON phase ends, saturating at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if ((state == IDLE) && (state_nxt == ON)) begin
            remaining <= blink_count;
        end else if ((state == ON) && tmr_expired && !cancel && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

endmodule

// File: doc/led_blink.md
LED_BLINK -- requirements
Module: led_blink

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 4, meaning the number of clock cycles the LED is lit per blink (minimum 1).
REQ-002 SHALL have parameter OFF_CYCLES, default 4, meaning the number of clock cycles the LED is dark between blinks (minimum 1).
REQ-003 SHALL have parameter CNT_W, default 4, meaning the width of the blink-count request.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request, typically a debounced button pulse.
REQ-007 SHALL have port blink_count, input, CNT_W bits: number of blinks requested, sampled only when start is accepted.
REQ-008 SHALL have port cancel, input, 1 bit: abort the current sequence.
REQ-009 SHALL have port led, output, 1 bit: LED drive, 1 = lit.
REQ-010 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-012 SHALL implement FSM states IDLE, ON and OFF; led = 1 only in ON; busy = 1 in ON or OFF.
REQ-013 SHALL accept start only in IDLE with blink_count != 0; start with blink_count = 0 is ignored and the block stays IDLE.
REQ-014 SHALL ignore start while busy; there is no queueing of requests.
REQ-015 SHALL, on acceptance at edge k, enter ON at edge k; led and busy are high in the cycle following edge k (1-cycle latency).
REQ-016 SHALL hold ON for exactly ON_CYCLES cycles, then hold OFF for exactly OFF_CYCLES cycles, repeating until blink_count ON phases have completed.
REQ-017 SHALL go from the final ON phase directly to IDLE with no trailing OFF phase; total busy time = N*ON_CYCLES + (N-1)*OFF_CYCLES cycles for N blinks.
REQ-018 SHALL assert done for exactly one cycle, in the first IDLE cycle after a normal completion.
REQ-019 SHALL, when cancel is sampled high in ON or OFF, go to IDLE at that edge with led = 0 and busy = 0, and SHALL NOT assert done.
REQ-020 SHALL ignore cancel in IDLE; when cancel and start are both high in IDLE, cancel takes priority and start is ignored.
REQ-021 SHALL use a remaining-blink counter of CNT_W bits loaded from blink_count, decremented at the end of each ON phase, and never wrapped below 0.
REQ-022 SHALL use a phase timer of $clog2(max(ON_CYCLES, OFF_CYCLES)+1) bits, loaded at each phase entry; the phase ends when the timer reaches its terminal value.
REQ-023 SHALL support the maximum request 2**CNT_W-1 blinks with no counter overflow.
REQ-024 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, while rst_n = 0 at a clock edge, set state = IDLE, led = 0, busy = 0, done = 0, and clear both counters.
REQ-026 SHALL give reset priority over cancel and start, including when reset arrives mid-sequence; no done pulse follows such a reset.
REQ-027 SHALL accept a start in the first cycle after rst_n returns high.

Structure
REQ-028 SHALL declare the state enum typedef (IDLE/ON/OFF) in shared package led_blink_pkg.
REQ-029 SHALL place the loadable down-counter phase timer in sub-module phase_timer (ports: clk, rst_n, load, load_val, expired).
REQ-030 SHALL keep the blink counter and the FSM in led_blink itself.

Verification (ON_CYCLES=4, OFF_CYCLES=3, CNT_W=4)
REQ-031 SHALL verify single-blink timing: start with blink_count=1 -> led high 4 cycles starting 1 cycle after start, busy high 4 cycles, done pulse in the next cycle.
REQ-032 SHALL verify a multi-blink sequence: blink_count=3 -> led pattern 1111 000 1111 000 1111, busy high 18 cycles, exactly one done pulse.
REQ-033 SHALL verify ignored starts: blink_count=0 -> no activity; a second start during a blink_count=2 sequence -> exactly 2 blinks, with total length unchanged.
REQ-034 SHALL verify cancel: cancel in the 2nd cycle of OFF of a blink_count=3 sequence -> led=0 and busy=0 the next cycle, done never asserted; simultaneous cancel and start in IDLE -> nothing happens.
REQ-035 SHALL verify reset mid-sequence: rst_n low for 1 cycle during ON -> all outputs 0 the next cycle, no done; start 1 cycle after release -> normal sequence.
REQ-036 SHALL verify maximum count: blink_count=15 -> 15 blinks, busy high 102 cycles, a single done pulse.
